// File: rtl/lpm_seq_accumulator.sv
// Sequential radix-4 digit feeder and shifted accumulator for the LPM.
// Optional early termination on zero digits: define LPM_ZERO_SKIP_EN.
module lpm_seq_accumulator #(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   a_in,
   input  logic [N-1:0]   b_in,
   output logic [N-1:0]   pp_b,
   output logic           pp_a1,
   output logic           pp_a0,
   input  logic [N:0]     pp_so,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] product,
   output logic           busy
);

   localparam int S  = N / 2;
   localparam int SW = (S > 1) ? $clog2(S) : 1;
   localparam int W  = 2 * N;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   state_e          state_q, state_d;
   logic [N-1:0]    a_q, a_d;
   logic [N-1:0]    b_q, b_d;
   logic [W-1:0]    acc_q, acc_d;
   logic [SW-1:0]   step_q, step_d;

   logic [N-1:0]    a_shift;
   logic [1:0]      digit;
   logic [W-1:0]    pp_ext;
   logic [W-1:0]    pp_sh;
   logic            last_step;
   logic            stop_run;

   // Current digit selection and weighted partial product.
   always_comb begin
      a_shift   = a_q >> {step_q, 1'b0};
      digit     = a_shift[1:0];
      pp_ext    = {{(W-N-1){1'b0}}, pp_so};
      pp_sh     = pp_ext << {step_q, 1'b0};
      last_step = (step_q == SW'(S - 1));
`ifdef LPM_ZERO_SKIP_EN
      stop_run  = last_step || ((a_shift >> 2) == '0);
`else
      stop_run  = last_step;
`endif
   end

   // Next-state logic for the control FSM and datapath registers.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      step_d  = step_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d    = a_in;
               b_d    = b_in;
               acc_d  = '0;
               step_d = '0;
`ifdef LPM_ZERO_SKIP_EN
               state_d = (a_in == '0) ? DONE : RUN;
`else
               state_d = RUN;
`endif
            end
         end
         RUN: begin
            acc_d  = acc_q + pp_sh;
            step_d = step_q + SW'(1);
            if (stop_run) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         step_q  <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         step_q  <= step_d;
      end
   end

   // Handshake and generator outputs; generator inputs parked at zero
   // outside RUN so it does not toggle.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      product   = '0;
      pp_b      = '0;
      pp_a1     = 1'b0;
      pp_a0     = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
         end
         RUN: begin
            busy  = 1'b1;
            pp_b  = b_q;
            pp_a1 = digit[1];
            pp_a0 = digit[0];
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            product   = acc_q;
         end
         default: begin
            in_ready = 1'b0;
         end
      endcase
   end

endmodule
